// File: rtl/control_fsm.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback and
// drives the shared-datapath selects, plus a retired-instruction counter and sticky trap.
module control_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [1:0]  alu_a_sel,
  output logic        alu_b_sel,
  output logic [1:0]  alu_op,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic [31:0] instret,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_t      state_q, state_d;
  logic        illegal_q;
  logic [31:0] instret_q;

  logic isR, isI, isLoad, isStore, isBranch, isJal, isJalr, isLui, isAuipc, isKnown;
  logic [1:0] opAluA;
  logic       opAluB;
  logic [1:0] opAluOp;

  // funct3 is consumed by the ALU decoder in the datapath, not by the sequencer
  logic unusedFunct3;
  assign unusedFunct3 = ^funct3;

  assign isR      = (opcode == OP_R);
  assign isI      = (opcode == OP_I);
  assign isLoad   = (opcode == OP_LOAD);
  assign isStore  = (opcode == OP_STORE);
  assign isBranch = (opcode == OP_BRANCH);
  assign isJal    = (opcode == OP_JAL);
  assign isJalr   = (opcode == OP_JALR);
  assign isLui    = (opcode == OP_LUI);
  assign isAuipc  = (opcode == OP_AUIPC);
  assign isKnown  = isR | isI | isLoad | isStore | isBranch | isJal | isJalr | isLui | isAuipc;

  // ALU operand/op choice per opcode; EXECUTE sets it and MEMORY/WRITEBACK hold it
  always_comb begin
    opAluA  = 2'd0;
    opAluB  = 1'b0;
    opAluOp = 2'd0;
    if (isR) begin
      opAluOp = 2'd1;
    end else if (isI) begin
      opAluB  = 1'b1;
      opAluOp = 2'd1;
    end else if (isLoad || isStore || isJalr) begin
      opAluB  = 1'b1;
    end else if (isAuipc) begin
      opAluA  = 2'd1;
      opAluB  = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'd0;
    alu_a_sel    = 2'd0;
    alu_b_sel    = 1'b0;
    alu_op       = 2'd0;
    rf_we        = 1'b0;
    wb_sel       = 2'd0;

    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = DECODE;
        end
      end

      DECODE: begin
        state_d = isKnown ? EXECUTE : TRAP;
      end

      EXECUTE: begin
        if (isBranch) begin
          alu_op  = 2'd2;
          pc_we   = 1'b1;
          pc_sel  = branch_taken ? 2'd1 : 2'd0;
          state_d = FETCH;
        end else begin
          alu_a_sel = opAluA;
          alu_b_sel = opAluB;
          alu_op    = opAluOp;
          state_d   = (isLoad || isStore) ? MEMORY : WRITEBACK;
        end
      end

      MEMORY: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = isStore;
        alu_a_sel    = opAluA;
        alu_b_sel    = opAluB;
        alu_op       = opAluOp;
        if (mem_ready) begin
          if (isStore) begin
            pc_we   = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WRITEBACK;
          end
        end
      end

      WRITEBACK: begin
        rf_we     = 1'b1;
        pc_we     = 1'b1;
        alu_a_sel = opAluA;
        alu_b_sel = opAluB;
        alu_op    = opAluOp;
        if (isLoad) begin
          wb_sel = 2'd1;
        end else if (isLui) begin
          wb_sel = 2'd3;
        end else if (isJal) begin
          wb_sel = 2'd2;
          pc_sel = 2'd1;
        end else if (isJalr) begin
          wb_sel = 2'd2;
          pc_sel = 2'd2;
        end
        state_d = FETCH;
      end

      TRAP: begin
        state_d = TRAP;
      end

      default: begin
        state_d = FETCH;
      end
    endcase

    // A reset cycle abandons any in-flight transaction without committing it
    if (reset) begin
      ir_we = 1'b0;
      pc_we = 1'b0;
      rf_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
      instret_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_d == TRAP) begin
        illegal_q <= 1'b1;
      end
      if (pc_we) begin
        instret_q <= instret_q + 32'd1;
      end
    end
  end

  assign illegal = illegal_q;
  assign instret = instret_q;
  assign state   = state_q;

endmodule
